ser_fifo: RTL and testbench

- Parametrised successor to the single-byte serial port: 8N1 UART with a receive FIFO, a transmit FIFO and a runtime-programmable baud divisor.
- Sits on the I/O bus with the same en/wr/addr/data register handshake, zero wait states and separate rx/tx interrupt lines.
- Register map grows to 8 words; the FIFOs let software service bursts without per-byte interrupts.

---
 rtl/ser_fifo.sv | 195 +++++++++++++++++++
 tb/tb_ser_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ser_fifo.sv
// rtl/ser_fifo.sv - 8N1 UART with rx/tx FIFOs and programmable baud divisor
module ser_fifo #(
  parameter int          FIFO_AW  = 4,
  parameter logic [15:0] BAUD_DIV = 16'd434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       wt,
  output logic       irq_r,
  output logic       irq_t,
  input  logic       rxd,
  output logic       txd
);

  localparam int DEPTH = 2 ** FIFO_AW;
  typedef logic [FIFO_AW:0] ptr_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];
  ptr_t rx_wp, rx_rp, tx_wp, tx_rp, rx_lvl, tx_lvl;
  logic rx_empty, rx_full, tx_empty, tx_full;

  logic        rien, tien, ovr, ferr;
  logic [15:0] div;
  logic [15:0] div_wr;
  logic        bus_wr, bus_rd, rx_pop, tx_push, tx_idle;

  logic   rs1, rx_s, rx_prev, rx_fall;
  state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sr, rx_sr_n;
  logic        rx_done, rx_push, rx_ferr_set, rx_ovr_set;

  state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sr, tx_sr_n;
  logic        tx_pop;

  assign rx_lvl   = rx_wp - rx_rp;
  assign tx_lvl   = tx_wp - tx_rp;
  assign rx_empty = (rx_lvl == '0);
  assign tx_empty = (tx_lvl == '0);
  assign rx_full  = rx_lvl[FIFO_AW];
  assign tx_full  = tx_lvl[FIFO_AW];

  assign bus_wr  = en & wr;
  assign bus_rd  = en & ~wr;
  assign rx_pop  = bus_rd & (addr == 3'd1) & ~rx_empty;
  assign tx_push = bus_wr & (addr == 3'd3) & ~tx_full;
  assign rx_push = rx_done & ~rx_full;
  assign rx_ovr_set = rx_done & rx_full;
  assign tx_idle = tx_empty & (tx_state == S_IDLE);
  assign rx_fall = rx_prev & ~rx_s;

  assign wt    = 1'b0;
  assign irq_r = rien & ~rx_empty;
  assign irq_t = tien & ~tx_full;
  assign txd   = (tx_state == S_START) ? 1'b0 :
                 (tx_state == S_DATA)  ? tx_sr[0] : 1'b1;

  // New divisor value for a DIVL/DIVH write, clamped so div/2 never reaches 0
  always_comb begin
    div_wr = (addr == 3'd4) ? {div[15:8], data_in} : {data_in, div[7:0]};
    if (div_wr < 16'd4) div_wr = 16'd4;
  end

  // Combinational register read mux
  always_comb begin
    data_out = 8'h00;
    case (addr)
      3'd0: data_out = {4'b0, ferr, ovr, rien, ~rx_empty};
      3'd1: data_out = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];
      3'd2: data_out = {5'b0, tx_idle, tien, ~tx_full};
      3'd4: data_out = div[7:0];
      3'd5: data_out = div[15:8];
      3'd6: data_out = 8'(rx_lvl);
      3'd7: data_out = 8'(tx_lvl);
      default: data_out = 8'h00;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sr;
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= data_in;
  end

  // Control registers, FIFO pointers and rxd synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp <= '0; rx_rp <= '0; tx_wp <= '0; tx_rp <= '0;
      rien <= 1'b0; tien <= 1'b0; ovr <= 1'b0; ferr <= 1'b0;
      div <= BAUD_DIV;
      rs1 <= 1'b1; rx_s <= 1'b1; rx_prev <= 1'b1;
    end else begin
      rs1 <= rxd; rx_s <= rs1; rx_prev <= rx_s;
      if (rx_push) rx_wp <= rx_wp + ptr_t'(1);
      if (rx_pop)  rx_rp <= rx_rp + ptr_t'(1);
      if (tx_push) tx_wp <= tx_wp + ptr_t'(1);
      if (tx_pop)  tx_rp <= tx_rp + ptr_t'(1);
      if (bus_wr && addr == 3'd0) rien <= data_in[1];
      if (bus_wr && addr == 3'd2) tien <= data_in[1];
      if (bus_wr && (addr == 3'd4 || addr == 3'd5)) div <= div_wr;
      // hardware set takes priority over a same-cycle W1C
      if (rx_ovr_set) ovr <= 1'b1;
      else if (bus_wr && addr == 3'd0 && data_in[2]) ovr <= 1'b0;
      if (rx_ferr_set) ferr <= 1'b1;
      else if (bus_wr && addr == 3'd0 && data_in[3]) ferr <= 1'b0;
    end
  end

  // Engine state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= S_IDLE; rx_cnt <= '0; rx_div <= '0; rx_bit <= '0; rx_sr <= '0;
      tx_state <= S_IDLE; tx_cnt <= '0; tx_div <= '0; tx_bit <= '0; tx_sr <= '0;
    end else begin
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_div <= rx_div_n;
      rx_bit <= rx_bit_n; rx_sr <= rx_sr_n;
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_div <= tx_div_n;
      tx_bit <= tx_bit_n; tx_sr <= tx_sr_n;
    end
  end

  // Receiver next state: counter expires when it reaches 1, giving N-clock periods
  always_comb begin
    rx_state_n = rx_state; rx_cnt_n = rx_cnt; rx_div_n = rx_div;
    rx_bit_n = rx_bit; rx_sr_n = rx_sr;
    rx_done = 1'b0; rx_ferr_set = 1'b0;
    case (rx_state)
      S_IDLE: if (rx_fall) begin
        rx_state_n = S_START;
        rx_cnt_n   = {1'b0, div[15:1]};
        rx_div_n   = div;
      end
      S_START: if (rx_cnt == 16'd1) begin
        rx_state_n = rx_s ? S_IDLE : S_DATA;
        rx_cnt_n   = rx_div;
        rx_bit_n   = 3'd0;
      end else rx_cnt_n = rx_cnt - 16'd1;
      S_DATA: if (rx_cnt == 16'd1) begin
        rx_sr_n  = {rx_s, rx_sr[7:1]};
        rx_cnt_n = rx_div;
        rx_bit_n = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = S_STOP;
      end else rx_cnt_n = rx_cnt - 16'd1;
      S_STOP: if (rx_cnt == 16'd1) begin
        rx_state_n  = S_IDLE;
        rx_ferr_set = ~rx_s;
        rx_done     = 1'b1;
      end else rx_cnt_n = rx_cnt - 16'd1;
      default: rx_state_n = S_IDLE;
    endcase
  end

  // Transmitter next state: frames chain back-to-back while the FIFO has data
  always_comb begin
    tx_state_n = tx_state; tx_cnt_n = tx_cnt; tx_div_n = tx_div;
    tx_bit_n = tx_bit; tx_sr_n = tx_sr;
    tx_pop = 1'b0;
    case (tx_state)
      S_IDLE: if (!tx_empty) begin
        tx_state_n = S_START; tx_pop = 1'b1;
        tx_cnt_n = div; tx_div_n = div;
        tx_sr_n = tx_mem[tx_rp[FIFO_AW-1:0]];
      end
      S_START: if (tx_cnt == 16'd1) begin
        tx_state_n = S_DATA; tx_cnt_n = tx_div; tx_bit_n = 3'd0;
      end else tx_cnt_n = tx_cnt - 16'd1;
      S_DATA: if (tx_cnt == 16'd1) begin
        tx_sr_n  = {1'b0, tx_sr[7:1]};
        tx_cnt_n = tx_div;
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_n = S_STOP;
      end else tx_cnt_n = tx_cnt - 16'd1;
      S_STOP: if (tx_cnt == 16'd1) begin
        if (!tx_empty) begin
          tx_state_n = S_START; tx_pop = 1'b1;
          tx_cnt_n = div; tx_div_n = div;
          tx_sr_n = tx_mem[tx_rp[FIFO_AW-1:0]];
        end else tx_state_n = S_IDLE;
      end else tx_cnt_n = tx_cnt - 16'd1;
      default: tx_state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ser_fifo.sv
// tb/tb_ser_fifo.sv - directed self-checking bench for ser_fifo
module tb_ser_fifo;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0, wr = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       wt, irq_r, irq_t;
  logic       rxd = 1'b1;
  logic       txd;

  int errors = 0;
  int checks = 0;
  logic [7:0]  d;
  logic [9:0]  fr1;
  logic [19:0] fr2;

  ser_fifo #(.FIFO_AW(4), .BAUD_DIV(16'd434)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .wt(wt), .irq_r(irq_r),
    .irq_t(irq_t), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] v);
    addr = a;
    #1;
    v = data_out;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    en = 1'b1; wr = 1'b1; addr = a; data_in = v;
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] v);
    @(posedge clk); #1;
    en = 1'b1; wr = 1'b0; addr = a;
    #1;
    v = data_out;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // one 8N1 frame at 8 clocks per bit, followed by 8 idle clocks
  task automatic send_rx(input logic [7:0] b, input logic stopb);
    @(posedge clk); #1;
    rxd = 1'b0; tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; tick(8);
    end
    rxd = stopb; tick(8);
    rxd = 1'b1; tick(8);
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_txd", 8'(txd), 8'd1);
    check("rst_irq_r", 8'(irq_r), 8'd0);
    check("rst_irq_t", 8'(irq_t), 8'd0);
    check("rst_wt", 8'(wt), 8'd0);
    peek(3'd0, d); check("rst_rctl", d, 8'h00);
    peek(3'd2, d); check("rst_xctl", d, 8'h05);
    peek(3'd4, d); check("rst_divl", d, 8'hB2);
    peek(3'd5, d); check("rst_divh", d, 8'h01);
    peek(3'd6, d); check("rst_rlvl", d, 8'h00);
    peek(3'd7, d); check("rst_xlvl", d, 8'h00);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // single frame 0x55 at div=434
    fr1 = {1'b1, 8'h55, 1'b0};
    bus_write(3'd3, 8'h55);
    check("tx1_pre_start", 8'(txd), 8'd1);
    tick(1);
    check("tx1_start_first", 8'(txd), 8'd0);
    tick(433);
    check("tx1_start_last", 8'(txd), 8'd0);
    tick(1);
    check("tx1_bit0_first", 8'(txd), 8'd1);
    tick(217);
    for (int k = 1; k < 10; k++) begin
      check($sformatf("tx1_bit%0d", k), 8'(txd), 8'(fr1[k]));
      if (k < 9) tick(434);
    end
    tick(216);
    peek(3'd2, d); check("tx1_busy_4339", d, 8'h01);
    tick(1);
    peek(3'd2, d); check("tx1_idle_4340", d, 8'h05);

    // divisor clamp, then div=8 back-to-back frames
    bus_write(3'd5, 8'h00);
    bus_write(3'd4, 8'h02);
    peek(3'd4, d); check("div_clamp", d, 8'h04);
    bus_write(3'd4, 8'h08);
    peek(3'd4, d); check("divl_8", d, 8'h08);
    fr2 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    bus_write(3'd3, 8'hA5);
    bus_write(3'd3, 8'h3C);
    peek(3'd7, d); check("tx2_xlvl_after_push", d, 8'h01);
    tick(3);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("tx2_bit%0d", k), 8'(txd), 8'(fr2[k]));
      if (k == 10) begin
        peek(3'd7, d); check("tx2_xlvl_frame2", d, 8'h00);
      end
      tick(8);
    end
    peek(3'd2, d); check("tx2_idle", d, 8'h05);

    // 17 rx frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_rx(8'(i), 1'b1);
    peek(3'd6, d); check("rx_lvl_full", d, 8'h10);
    peek(3'd0, d); check("rx_rctl_ovr", d, 8'h05);
    for (int i = 0; i < 16; i++) begin
      bus_read(3'd1, d);
      check($sformatf("rx_data%0d", i), d, 8'(i));
    end
    bus_read(3'd1, d); check("rx_read_empty", d, 8'h00);
    peek(3'd6, d); check("rx_lvl_empty", d, 8'h00);
    peek(3'd0, d); check("rx_rctl_after", d, 8'h04);

    // framing error, W1C
    bus_write(3'd0, 8'h04);
    peek(3'd0, d); check("ovr_cleared", d, 8'h00);
    send_rx(8'h81, 1'b0);
    peek(3'd0, d); check("ferr_set", d, 8'h09);
    bus_write(3'd0, 8'h08);
    peek(3'd0, d); check("ferr_cleared", d, 8'h01);
    bus_read(3'd1, d); check("ferr_byte", d, 8'h81);

    // glitch rejection, then a clean frame
    @(posedge clk); #1;
    rxd = 1'b0; tick(2);
    rxd = 1'b1; tick(20);
    peek(3'd6, d); check("glitch_lvl", d, 8'h00);
    send_rx(8'h5A, 1'b1);
    peek(3'd6, d); check("post_glitch_lvl", d, 8'h01);
    bus_read(3'd1, d); check("post_glitch_byte", d, 8'h5A);

    // interrupts
    bus_write(3'd0, 8'h02);
    check("irq_r_empty", 8'(irq_r), 8'd0);
    send_rx(8'hC3, 1'b1);
    check("irq_r_set", 8'(irq_r), 8'd1);
    peek(3'd0, d); check("rctl_ien_rdy", d, 8'h03);
    bus_read(3'd1, d); check("irq_byte", d, 8'hC3);
    check("irq_r_clear", 8'(irq_r), 8'd0);
    check("irq_t_off", 8'(irq_t), 8'd0);
    bus_write(3'd2, 8'h02);
    check("irq_t_on", 8'(irq_t), 8'd1);

    // reset mid-frame
    bus_write(3'd3, 8'h00);
    bus_write(3'd3, 8'h00);
    tick(20);
    check("mid_txd_low", 8'(txd), 8'd0);
    peek(3'd7, d); check("mid_xlvl", d, 8'h01);
    reset_n = 1'b0;
    #1;
    check("rst_mid_txd", 8'(txd), 8'd1);
    check("rst_mid_irq_t", 8'(irq_t), 8'd0);
    peek(3'd7, d); check("rst_mid_xlvl", d, 8'h00);
    peek(3'd4, d); check("rst_mid_divl", d, 8'hB2);
    peek(3'd5, d); check("rst_mid_divh", d, 8'h01);
    peek(3'd2, d); check("rst_mid_xctl", d, 8'h05);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("post_rst_txd", 8'(txd), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
